// File: rtl/apb_bits_regs_if.sv
// APB bus bundle between the bench master and the BITS register block.
interface apb_bits_regs_if;
   logic [7:0]  paddr;
   logic        pwrite;
   logic        psel;
   logic        penable;
   logic [31:0] pwdata;
   logic [31:0] prdata;

   modport master (
      output paddr, pwrite, psel, penable, pwdata,
      input  prdata
   );

   modport slave (
      input  paddr, pwrite, psel, penable, pwdata,
      output prdata
   );
endinterface

// File: rtl/apb_bits_regs.sv
// APB register block feeding the BITS decoder: word FIFO, start pulse,
// captured 64-bit result and sticky status flags.
module apb_bits_regs #(
   parameter int unsigned DEPTH    = 16,
   parameter logic [31:0] ID_VALUE = 32'h0AC0_2116
) (
   input  logic                  clk,
   input  logic                  rst,
   apb_bits_regs_if.slave        apb,
   output logic [31:0]           word_data,
   output logic                  word_valid,
   input  logic                  word_ready,
   output logic                  start,
   input  logic [63:0]           result,
   input  logic                  result_valid
);

   localparam int unsigned AW       = $clog2(DEPTH);
   localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);

   localparam logic [7:0] ADDR_CTRL   = 8'h00;
   localparam logic [7:0] ADDR_STATUS = 8'h04;
   localparam logic [7:0] ADDR_DATA   = 8'h08;
   localparam logic [7:0] ADDR_RES_LO = 8'h0C;
   localparam logic [7:0] ADDR_RES_HI = 8'h10;
   localparam logic [7:0] ADDR_ID     = 8'h14;

   logic          setup;
   logic          setup_q;
   logic          commit;
   logic          wr_commit;
   logic          ctrl_wr;
   logic          data_push;
   logic          fifo_clr;
   logic          pop;
   logic          push_ok;

   logic [31:0]   mem [DEPTH];
   logic [AW-1:0] wptr;
   logic [AW-1:0] rptr;
   logic [AW:0]   count;
   logic          ovf;
   logic          done;
   logic [63:0]   res_q;
   logic [31:0]   status;
   logic [31:0]   rd_mux;

   // Commit only on the access cycle that directly follows a setup cycle,
   // so a held psel/penable cannot repeat the access.
   assign setup     = apb.psel & ~apb.penable;
   assign commit    = apb.psel & apb.penable & setup_q;
   assign wr_commit = commit & apb.pwrite;
   assign ctrl_wr   = wr_commit & (apb.paddr == ADDR_CTRL);
   assign data_push = wr_commit & (apb.paddr == ADDR_DATA);
   assign fifo_clr  = ctrl_wr & apb.pwdata[1];

   assign word_valid = (count != '0);
   assign word_data  = word_valid ? mem[rptr] : '0;
   assign pop        = word_valid & word_ready;
   // A full FIFO still accepts a push when the head leaves in the same cycle.
   assign push_ok    = data_push & ((count != FULL_CNT) | pop);

   // Remember whether the previous cycle was an APB setup cycle.
   always_ff @(posedge clk) begin
      if (rst) setup_q <= 1'b0;
      else     setup_q <= setup;
   end

   // FIFO storage; contents are meaningless once pointers are reset.
   always_ff @(posedge clk) begin
      if (push_ok) mem[wptr] <= apb.pwdata;
   end

   // FIFO pointers and occupancy; clear overrides a simultaneous pop.
   always_ff @(posedge clk) begin
      if (rst || fifo_clr) begin
         wptr  <= '0;
         rptr  <= '0;
         count <= '0;
      end else begin
         if (push_ok) wptr <= wptr + 1'b1;
         if (pop)     rptr <= rptr + 1'b1;
         case ({push_ok, pop})
            2'b10:   count <= count + 1'b1;
            2'b01:   count <= count - 1'b1;
            default: count <= count;
         endcase
      end
   end

   // Sticky overflow: a dropped push sets it, W1C clears, set wins.
   always_ff @(posedge clk) begin
      if (rst)                            ovf <= 1'b0;
      else if (data_push && !push_ok)     ovf <= 1'b1;
      else if (ctrl_wr && apb.pwdata[2])  ovf <= 1'b0;
   end

   // Sticky done: result strobe sets it; start or W1C clears, set wins.
   always_ff @(posedge clk) begin
      if (rst)                                          done <= 1'b0;
      else if (result_valid)                            done <= 1'b1;
      else if (ctrl_wr && (apb.pwdata[0] || apb.pwdata[3])) done <= 1'b0;
   end

   // Capture the decoder answer on its strobe.
   always_ff @(posedge clk) begin
      if (rst)               res_q <= '0;
      else if (result_valid) res_q <= result;
   end

   // One-cycle start pulse in the cycle after the CTRL commit.
   always_ff @(posedge clk) begin
      if (rst) start <= 1'b0;
      else     start <= ctrl_wr & apb.pwdata[0];
   end

   // Assemble STATUS and select the read register.
   always_comb begin
      status            = '0;
      status[0]         = ~word_valid;
      status[1]         = (count == FULL_CNT);
      status[2]         = ovf;
      status[3]         = done;
      status[8 +: AW+1] = count;
      rd_mux            = '0;
      case (apb.paddr)
         ADDR_STATUS: rd_mux = status;
         ADDR_RES_LO: rd_mux = res_q[31:0];
         ADDR_RES_HI: rd_mux = res_q[63:32];
         ADDR_ID:     rd_mux = ID_VALUE;
         default:     rd_mux = '0;
      endcase
   end

   // Read data is loaded on a read setup cycle and held until the next one.
   always_ff @(posedge clk) begin
      if (rst)                        apb.prdata <= '0;
      else if (setup && !apb.pwrite)  apb.prdata <= rd_mux;
   end

endmodule

// File: tb/tb_apb_bits_regs.sv
// Scoreboard bench for apb_bits_regs: stimulus pushes expectations,
// a negedge monitor pops and compares reads, FIFO pops and start pulses.
module tb_apb_bits_regs;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic [31:0] word_data;
   logic        word_valid;
   logic        word_ready = 1'b0;
   logic        start;
   logic [63:0] result = '0;
   logic        result_valid = 1'b0;

   int unsigned cyc = 0;
   int          n_checks = 0;
   int          n_fail = 0;

   logic [31:0] rd_q[$];
   logic [31:0] word_q[$];
   int unsigned start_q[$];

   apb_bits_regs_if bus();

   apb_bits_regs #(.DEPTH(16), .ID_VALUE(32'h0AC0_2116)) dut (
      .clk          (clk),
      .rst          (rst),
      .apb          (bus),
      .word_data    (word_data),
      .word_valid   (word_valid),
      .word_ready   (word_ready),
      .start        (start),
      .result       (result),
      .result_valid (result_valid)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   task automatic apb_write(input logic [7:0] a, input logic [31:0] d, input bit ready_at_commit);
      @(posedge clk); #2;
      bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1;
      bus.paddr = a; bus.pwdata = d;
      @(posedge clk); #2;
      bus.penable = 1'b1;
      if (ready_at_commit) word_ready = 1'b1;
      @(posedge clk); #2;
      if (a == 8'h00 && d[0]) start_q.push_back(cyc);
      bus.psel = 1'b0; bus.penable = 1'b0;
      if (ready_at_commit) word_ready = 1'b0;
   endtask

   task automatic apb_read(input logic [7:0] a, input logic [31:0] exp);
      @(posedge clk); #2;
      bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b0; bus.paddr = a;
      rd_q.push_back(exp);
      @(posedge clk); #2;
      bus.penable = 1'b1;
      @(posedge clk); #2;
      bus.psel = 1'b0; bus.penable = 1'b0;
   endtask

   task automatic drain();
      bit emptied = 1'b0;
      @(posedge clk); #2;
      word_ready = 1'b1;
      for (int i = 0; i < 64; i++) begin
         @(posedge clk); #2;
         if (!word_valid) begin
            emptied = 1'b1;
            break;
         end
      end
      word_ready = 1'b0;
      check("drain_done", emptied, 1'b1);
   endtask

   // Monitor: compare every DUT output event against the scoreboard queues.
   always @(negedge clk) begin
      if (!rst) begin
         if (bus.psel && bus.penable && !bus.pwrite) begin
            if (rd_q.size() == 0) check("rd_unexpected", 1, 0);
            else                  check("prdata", bus.prdata, rd_q.pop_front());
         end
         if (word_valid && word_ready) begin
            if (word_q.size() == 0) check("pop_unexpected", 1, 0);
            else                    check("word_data", word_data, word_q.pop_front());
         end
         if (start) begin
            if (start_q.size() == 0) check("start_extra", 1, 0);
            else                     check("start_cycle", cyc, start_q.pop_front());
         end
      end
   end

   initial begin
      bus.psel = 1'b0; bus.penable = 1'b0; bus.pwrite = 1'b0;
      bus.paddr = '0; bus.pwdata = '0;
      repeat (3) @(posedge clk);
      #2;
      check("rst_prdata", bus.prdata, 0);
      check("rst_start", start, 0);
      check("rst_word_valid", word_valid, 0);
      check("rst_word_data", word_data, 0);
      rst = 1'b0;

      // ID, empty status, unmapped
      apb_read(8'h14, 32'h0AC0_2116);
      apb_read(8'h04, 32'h0000_0001);
      apb_read(8'h18, 32'h0000_0000);

      // Two words, then drain in order
      apb_write(8'h08, 32'hD2FE_28AB, 1'b0); word_q.push_back(32'hD2FE_28AB);
      apb_write(8'h08, 32'h1234_5678, 1'b0); word_q.push_back(32'h1234_5678);
      apb_read(8'h04, 32'h0000_0200);
      drain();
      apb_read(8'h04, 32'h0000_0001);

      // Overflow, W1C overflow, FIFO clear (words never popped)
      for (int i = 0; i < 17; i++) apb_write(8'h08, 32'h100 + i, 1'b0);
      apb_read(8'h04, 32'h0000_1006);
      apb_write(8'h00, 32'h4, 1'b0);
      apb_read(8'h04, 32'h0000_1002);
      apb_write(8'h00, 32'h2, 1'b0);
      apb_read(8'h04, 32'h0000_0001);

      // Full FIFO: push coincident with pop is accepted
      for (int i = 0; i < 16; i++) begin
         apb_write(8'h08, 32'hA0 + i, 1'b0);
         word_q.push_back(32'hA0 + i);
      end
      apb_write(8'h08, 32'hCAFE_F00D, 1'b1); word_q.push_back(32'hCAFE_F00D);
      apb_read(8'h04, 32'h0000_1002);
      drain();
      apb_read(8'h04, 32'h0000_0001);

      // Start pulse, result capture, done cleared by start
      apb_write(8'h00, 32'h1, 1'b0);
      @(posedge clk); #2;
      result = 64'h0000_0001_0000_0010; result_valid = 1'b1;
      @(posedge clk); #2;
      result_valid = 1'b0; result = '0;
      apb_read(8'h0C, 32'h0000_0010);
      apb_read(8'h10, 32'h0000_0001);
      apb_read(8'h04, 32'h0000_0009);
      apb_write(8'h00, 32'h1, 1'b0);
      apb_read(8'h04, 32'h0000_0001);
      apb_read(8'h0C, 32'h0000_0010);

      // Access phase held for 5 cycles commits once
      @(posedge clk); #2;
      bus.psel = 1'b1; bus.penable = 1'b0; bus.pwrite = 1'b1;
      bus.paddr = 8'h08; bus.pwdata = 32'h5555_AAAA;
      @(posedge clk); #2;
      bus.penable = 1'b1;
      repeat (5) @(posedge clk);
      #2;
      bus.psel = 1'b0; bus.penable = 1'b0;
      apb_read(8'h04, 32'h0000_0100);
      apb_write(8'h00, 32'h2, 1'b0);
      apb_read(8'h04, 32'h0000_0001);

      repeat (4) @(posedge clk);
      #2;
      check("rd_q_empty", rd_q.size(), 0);
      check("word_q_empty", word_q.size(), 0);
      check("start_q_empty", start_q.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
